// File: rtl/pwm_decoder.sv
// pwm_decoder: measures the period and high time of a PWM input and converts
// the duty cycle back into a 4-bit level code (floor(high*16/period), max 15).
// Optional build macro PWM_DEC_GLITCH_FILTER_EN adds a 3-sample majority
// filter after the synchronizer, which rejects 1-cycle pulses.
// Ports:
//   clk     in   system clock, rising edge
//   rst_n   in   synchronous active-low reset
//   pwm_in  in   asynchronous PWM waveform
//   duty    out  decoded 4-bit level (tracks the pin level while stuck)
//   period  out  last measured period in clk cycles
//   upd     out  one-cycle strobe when duty/period update
//   valid   out  at least one period decoded since reset/stuck
//   stuck   out  no rising edge for 2^CNT_W-1 cycles
module pwm_decoder #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             pwm_in,
   output logic [3:0]       duty,
   output logic [CNT_W-1:0] period,
   output logic             upd,
   output logic             valid,
   output logic             stuck
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ARM,
      S_RUN
   } state_t;

   localparam logic [CNT_W-1:0] MAXC = '1;
   localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

   state_t           r_state;
   logic             r_s1;
   logic             r_s2;
   logic             r_prev;
   logic [CNT_W-1:0] r_pcnt;
   logic [CNT_W-1:0] r_hcnt;
   logic [CNT_W-1:0] r_p;
   logic [CNT_W:0]   r_rem;
   logic [3:0]       r_q;
   logic [1:0]       r_dcnt;
   logic             r_busy;
   logic             r_wb;
   logic             r_force;

   logic             w_pwm_s;
   logic             w_rise;
   logic             w_sat;
   logic [CNT_W:0]   w_r2;
   logic             w_ge;
   logic [CNT_W:0]   w_rn;

`ifdef PWM_DEC_GLITCH_FILTER_EN
   logic [2:0] r_f;

   always_ff @(posedge clk) begin
      if (!rst_n) r_f <= '0;
      else        r_f <= {r_f[1:0], r_s2};
   end

   assign w_pwm_s = (r_f[0] & r_f[1]) |
                    (r_f[1] & r_f[2]) |
                    (r_f[0] & r_f[2]);
`else
   assign w_pwm_s = r_s2;
`endif

   assign w_rise = w_pwm_s & ~r_prev;
   // A rise on the saturating cycle wins: it is a valid, if maximal, period.
   assign w_sat  = (r_pcnt == MAXC) & ~w_rise;

   // One restoring step of the fractional divide r/P.
   assign w_r2 = {r_rem[CNT_W-1:0], 1'b0};
   assign w_ge = (w_r2 >= {1'b0, r_p});
   assign w_rn = w_ge ? (w_r2 - {1'b0, r_p}) : w_r2;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_s1   <= 1'b0;
         r_s2   <= 1'b0;
         r_prev <= 1'b0;
         r_pcnt <= '0;
         r_hcnt <= '0;
      end else begin
         r_s1   <= pwm_in;
         r_s2   <= r_s1;
         r_prev <= w_pwm_s;
         if (w_rise) begin
            r_pcnt <= ONE;
            r_hcnt <= ONE;
         end else begin
            if (r_pcnt != MAXC) r_pcnt <= r_pcnt + ONE;
            if (w_pwm_s && (r_hcnt != MAXC)) r_hcnt <= r_hcnt + ONE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_ARM;
         r_p     <= '0;
         r_rem   <= '0;
         r_q     <= '0;
         r_dcnt  <= '0;
         r_busy  <= 1'b0;
         r_wb    <= 1'b0;
         r_force <= 1'b0;
         duty    <= '0;
         period  <= '0;
         upd     <= 1'b0;
         valid   <= 1'b0;
         stuck   <= 1'b0;
      end else begin
         upd <= 1'b0;
         if (w_sat) begin
            r_state <= S_ARM;
            r_busy  <= 1'b0;
            r_wb    <= 1'b0;
            stuck   <= 1'b1;
            valid   <= 1'b0;
            duty    <= {4{w_pwm_s}};
         end else begin
            if (stuck) duty <= {4{w_pwm_s}};
            unique case (r_state)
               S_ARM: begin
                  if (w_rise) begin
                     r_state <= S_RUN;
                     stuck   <= 1'b0;
                  end
               end
               S_RUN: begin
                  if (w_rise && r_busy) begin
                     // Too short for the divider: drop the measurement.
                     r_busy <= 1'b0;
                     r_wb   <= 1'b0;
                  end else if (w_rise) begin
                     r_p     <= r_pcnt;
                     r_rem   <= {1'b0, r_hcnt};
                     r_force <= (r_hcnt >= r_pcnt);
                     r_q     <= '0;
                     r_dcnt  <= '0;
                     r_busy  <= 1'b1;
                     r_wb    <= 1'b0;
                  end else if (r_busy && r_wb) begin
                     duty   <= r_force ? 4'hF : r_q;
                     period <= r_p;
                     upd    <= 1'b1;
                     valid  <= 1'b1;
                     r_busy <= 1'b0;
                     r_wb   <= 1'b0;
                  end else if (r_busy) begin
                     r_rem  <= w_rn;
                     r_q    <= {r_q[2:0], w_ge};
                     r_dcnt <= r_dcnt + 2'd1;
                     if (r_dcnt == 2'd3) r_wb <= 1'b1;
                  end
               end
               default: r_state <= S_ARM;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_pwm_decoder.sv
// tb_pwm_decoder: directed self-checking bench for pwm_decoder.
// Instance A uses CNT_W=16, instance B uses CNT_W=8 for the stuck path.
module tb_pwm_decoder;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        pwm = 1'b0;

   logic [3:0]  duty_a;
   logic [15:0] period_a;
   logic        upd_a, valid_a, stuck_a;
   logic [3:0]  duty_b;
   logic [7:0]  period_b;
   logic        upd_b, valid_b, stuck_b;

   int n_cmp = 0;
   int n_bad = 0;
   int n_upd = 0;
   int n0;

   always #5 clk = ~clk;

   pwm_decoder #(.CNT_W(16)) u_a (
      .clk(clk), .rst_n(rst_n), .pwm_in(pwm),
      .duty(duty_a), .period(period_a), .upd(upd_a),
      .valid(valid_a), .stuck(stuck_a)
   );

   pwm_decoder #(.CNT_W(8)) u_b (
      .clk(clk), .rst_n(rst_n), .pwm_in(pwm),
      .duty(duty_b), .period(period_b), .upd(upd_b),
      .valid(valid_b), .stuck(stuck_b)
   );

   always @(posedge clk) if (upd_a) n_upd <= n_upd + 1;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d want %0d", tag, got, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic per(input int p, input int h);
      pwm = 1'b1;
      cyc(h);
      pwm = 1'b0;
      cyc(p - h);
   endtask

   task automatic do_rst();
      rst_n = 1'b0;
      cyc(2);
      rst_n = 1'b1;
      cyc(2);
   endtask

   initial begin
      // reset state
      cyc(3);
      rst_n = 1'b1;
      cyc(1);
      chk("rst_duty", duty_a, 0);
      chk("rst_period", period_a, 0);
      chk("rst_upd", upd_a, 0);
      chk("rst_valid", valid_a, 0);
      chk("rst_stuck", stuck_a, 0);

      // 160/50: first edge only arms
      per(160, 50);
      chk("arm_no_upd", n_upd, 0);
      per(160, 50);
      per(160, 50);
      chk("p160_nupd", n_upd, 2);
      chk("p160_duty", duty_a, 5);
      chk("p160_period", period_a, 160);
      chk("p160_valid", valid_a, 1);
      chk("b160_valid", valid_b, 1);
      chk("b160_duty", duty_b, 5);

      // stuck high on the 8-bit instance
      pwm = 1'b1;
      cyc(300);
      chk("stk_flag", stuck_b, 1);
      chk("stk_valid", valid_b, 0);
      chk("stk_duty_hi", duty_b, 15);
      chk("stk_a_clear", stuck_a, 0);
      pwm = 1'b0;
      cyc(8);
      chk("stk_duty_lo", duty_b, 0);
      chk("stk_hold", stuck_b, 1);
      pwm = 1'b1;
      cyc(12);
      chk("rearm_stuck", stuck_b, 0);
      chk("rearm_valid", valid_b, 0);
      cyc(13);
      pwm = 1'b0;
      cyc(75);
      pwm = 1'b1;
      cyc(12);
      chk("rearm_dvalid", valid_b, 1);
      chk("rearm_duty", duty_b, 4);
      chk("rearm_period", period_b, 100);
      pwm = 1'b0;
      cyc(20);

      // duty sweep at period 256
      for (int c = 1; c <= 16; c++) begin
         pwm = 1'b1;
         cyc(12);
         if (c > 1) chk("sweep", duty_a, c - 1);
         if (c == 16) begin
            chk("sweep_period", period_a, 256);
            break;
         end
         cyc(16 * c - 12);
         pwm = 1'b0;
         cyc(256 - 16 * c);
      end

      // period 4 never decodes
      pwm = 1'b0;
      do_rst();
      n0 = n_upd;
      repeat (21) per(4, 2);
      cyc(10);
      chk("p4_nupd", n_upd - n0, 0);
      chk("p4_valid", valid_a, 0);
      repeat (4) per(32, 16);
      pwm = 1'b1;
      cyc(12);
      chk("p32_duty", duty_a, 8);
      chk("p32_period", period_a, 32);
      chk("p32_valid", valid_a, 1);
      cyc(4);
      pwm = 1'b0;
      cyc(16);

      // reset two cycles into a divide
      do_rst();
      per(40, 20);
      n0 = n_upd;
      pwm = 1'b1;
      cyc(4);
      rst_n = 1'b0;
      cyc(1);
      rst_n = 1'b1;
      chk("mid_duty", duty_a, 0);
      chk("mid_period", period_a, 0);
      chk("mid_valid", valid_a, 0);
      chk("mid_stuck", stuck_a, 0);
      cyc(10);
      chk("mid_nupd", n_upd - n0, 0);
      chk("mid_armonly", valid_a, 0);
      pwm = 1'b0;
      cyc(20);
      per(40, 20);
      pwm = 1'b1;
      cyc(12);
      chk("mid_rdy_valid", valid_a, 1);
      chk("mid_rdy_duty", duty_a, 8);
      chk("mid_rdy_period", period_a, 40);
      cyc(8);
      pwm = 1'b0;
      cyc(20);

      // 1-cycle glitches in the low phase at 64/32
      do_rst();
      repeat (3) per(64, 32);
      repeat (3) begin
         pwm = 1'b1;
         cyc(32);
         pwm = 1'b0;
         cyc(15);
         pwm = 1'b1;
         cyc(1);
         pwm = 1'b0;
         cyc(16);
      end
      pwm = 1'b1;
      cyc(12);
`ifdef PWM_DEC_GLITCH_FILTER_EN
      chk("glitch_duty", duty_a, 8);
      chk("glitch_period", period_a, 64);
`else
      chk("glitch_duty", duty_a, 0);
      chk("glitch_period", period_a, 17);
`endif
      chk("glitch_valid", valid_a, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
